// File: rtl/alu_pkg.sv
// Shared types and constants for the stack-machine ALU.
package alu_pkg;

    localparam int unsigned ALU_W    = 16;
    localparam int unsigned ITER_CNT = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_DIV = 4'h3,
        OP_MOD = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_NOT = 4'h8,
        OP_NEG = 4'h9,
        OP_SHL = 4'hA,
        OP_SHR = 4'hB,
        OP_SRA = 4'hC,
        OP_EQ  = 4'hD,
        OP_LT  = 4'hE,
        OP_LTU = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIX,
        ST_FIN
    } alu_state_e;

    function automatic logic [ALU_W-1:0] magnitude(input logic [ALU_W-1:0] v);
        return v[ALU_W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider on one 32-bit accumulator.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [ALU_W-1:0] mag_a_i,
    input  logic [ALU_W-1:0] mag_b_i,
    output logic [2*ALU_W-1:0] prod_o,
    output logic [ALU_W-1:0] quot_o,
    output logic [ALU_W-1:0] rem_o,
    output logic             ready_o
);

    logic [2*ALU_W-1:0] acc_q, acc_d;
    logic [ALU_W-1:0]   opnd_q, opnd_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               div_q, div_d;

    logic [ALU_W:0]     add_sum;
    logic [ALU_W+1:0]   trial;

    always_ff @(posedge clock) begin
        if (reset_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        div_d   = div_q;
        add_sum = {1'b0, acc_q[2*ALU_W-1:ALU_W]} + {1'b0, opnd_q};
        // Shifted partial remainder minus divisor; the top bit flags a borrow.
        trial   = {1'b0, acc_q[2*ALU_W-1:ALU_W-1]} - {2'b00, opnd_q};

        if (start_i) begin
            acc_d  = {{ALU_W{1'b0}}, mag_a_i};
            opnd_d = mag_b_i;
            div_d  = is_div_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d  = cnt_q + 5'd1;
            busy_d = (cnt_q != 5'(ITER_CNT - 1));
            if (div_q) begin
                if (!trial[ALU_W+1])
                    acc_d = {trial[ALU_W-1:0], acc_q[ALU_W-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*ALU_W-2:0], 1'b0};
            end else begin
                if (acc_q[0])
                    acc_d = {add_sum, acc_q[ALU_W-1:1]};
                else
                    acc_d = {1'b0, acc_q[2*ALU_W-1:1]};
            end
        end
    end

    // High during the last iteration; results are stable from the next cycle on.
    assign ready_o = busy_q && (cnt_q == 5'(ITER_CNT - 1));
    assign prod_o  = acc_q;
    assign quot_o  = acc_q[ALU_W-1:0];
    assign rem_o   = acc_q[2*ALU_W-1:ALU_W];

endmodule

// File: rtl/alu_unit.sv
// Multi-cycle 16-bit ALU: single-cycle ops, sign handling and error detection around alu_muldiv.
module alu_unit
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [ALU_W-1:0] alu_a,
    input  logic [ALU_W-1:0] alu_b,
    input  logic [ALU_W-1:0] alu_op,
    input  logic             go,
    output logic [ALU_W-1:0] alu_out,
    output logic             done,
    output logic             err_flag
);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [ALU_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    alu_op_e          op_in;
    logic             illegal;
    logic             md_start;
    logic             md_ready;
    logic [2*ALU_W-1:0] md_prod;
    logic [ALU_W-1:0] md_quot, md_rem;

    logic [ALU_W-1:0] sc_res;
    logic             sc_err;
    logic [ALU_W-1:0] sum, dif;
    logic [3:0]       shamt;

    logic             neg_res;
    logic [2*ALU_W-1:0] prod_s;
    logic [ALU_W-1:0] quot_s, rem_s;
    logic [ALU_W-1:0] fix_res;
    logic             fix_err;

    assign op_in   = alu_op_e'(alu_op[3:0]);
    assign illegal = |alu_op[ALU_W-1:4];

    alu_muldiv u_muldiv (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (md_start),
        .is_div_i ((op_in == OP_DIV) || (op_in == OP_MOD)),
        .mag_a_i  (magnitude(alu_a)),
        .mag_b_i  (magnitude(alu_b)),
        .prod_o   (md_prod),
        .quot_o   (md_quot),
        .rem_o    (md_rem),
        .ready_o  (md_ready)
    );

    always_comb begin
        sum    = alu_a + alu_b;
        dif    = alu_a - alu_b;
        shamt  = alu_b[3:0];
        sc_res = '0;
        sc_err = 1'b0;
        case (op_in)
            OP_ADD: begin
                sc_res = sum;
                sc_err = (alu_a[ALU_W-1] == alu_b[ALU_W-1]) && (sum[ALU_W-1] != alu_a[ALU_W-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_err = (alu_a[ALU_W-1] != alu_b[ALU_W-1]) && (dif[ALU_W-1] != alu_a[ALU_W-1]);
            end
            OP_AND: sc_res = alu_a & alu_b;
            OP_OR:  sc_res = alu_a | alu_b;
            OP_XOR: sc_res = alu_a ^ alu_b;
            OP_NOT: sc_res = ~alu_a;
            OP_NEG: begin
                sc_res = '0 - alu_a;
                sc_err = (alu_a == {1'b1, {(ALU_W-1){1'b0}}});
            end
            OP_SHL: sc_res = alu_a << shamt;
            OP_SHR: sc_res = alu_a >> shamt;
            OP_SRA: sc_res = $signed(alu_a) >>> shamt;
            OP_EQ:  sc_res = {{(ALU_W-1){1'b0}}, alu_a == alu_b};
            OP_LT:  sc_res = {{(ALU_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            OP_LTU: sc_res = {{(ALU_W-1){1'b0}}, alu_a < alu_b};
            default: begin
                sc_res = '0;
                sc_err = 1'b0;
            end
        endcase
    end

    always_comb begin
        neg_res = sa_q ^ sb_q;
        prod_s  = neg_res ? ('0 - md_prod) : md_prod;
        quot_s  = neg_res ? ('0 - md_quot) : md_quot;
        rem_s   = sa_q ? ('0 - md_rem) : md_rem;
        fix_res = '0;
        fix_err = 1'b0;
        case (op_q)
            OP_MUL: begin
                fix_res = prod_s[ALU_W-1:0];
                fix_err = !((&prod_s[2*ALU_W-1:ALU_W-1]) || !(|prod_s[2*ALU_W-1:ALU_W-1]));
            end
            // A positive quotient of 32768 only arises from 16'h8000 / -1.
            OP_DIV: begin
                fix_res = quot_s;
                fix_err = !neg_res && md_quot[ALU_W-1];
            end
            default: begin
                fix_res = rem_s;
                fix_err = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        out_d    = out_q;
        err_d    = err_q;
        done_d   = 1'b0;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    op_d = op_in;
                    sa_d = alu_a[ALU_W-1];
                    sb_d = alu_b[ALU_W-1];
                    if (illegal) begin
                        out_d  = '0;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (is_muldiv(op_in)) begin
                        if ((op_in != OP_MUL) && (alu_b == '0)) begin
                            out_d  = '0;
                            err_d  = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            md_start = 1'b1;
                            state_d  = ST_ITER;
                        end
                    end else begin
                        out_d  = sc_res;
                        err_d  = sc_err;
                        done_d = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                if (md_ready)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                out_d   = fix_res;
                err_d   = fix_err;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_out  = out_q;
    assign err_flag = err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit.
module tb_alu_unit;

    logic        clock;
    logic        reset_n;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_op;
    logic        go;
    logic [15:0] alu_out;
    logic        done;
    logic        err_flag;

    int checks = 0;
    int errors = 0;

    alu_unit dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .go       (go),
        .alu_out  (alu_out),
        .done     (done),
        .err_flag (err_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Presents one go pulse; returns #1 after the go edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op);
        @(negedge clock);
        alu_a  = a;
        alu_b  = b;
        alu_op = op;
        go     = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
    endtask

    // off = number of rising edges after the go edge at which done went high.
    task automatic wait_done(output int off, output bit seen);
        off  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                off  = i;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        int n;
        reset_n = 1'b1;
        go      = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (alu_out !== 16'h0000 || done !== 1'b0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%h done=%b err=%b expected 0000/0/0", alu_out, done, err_flag);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (done) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL idle_no_done got %0d dones expected 0", n);
        end
    endtask

    task automatic test_add;
        int off; bit seen;
        start_op(16'h7FFF, 16'h0001, 16'h0000);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 0 || alu_out !== 16'h8000 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf seen=%b off=%0d out=%h err=%b expected 1/0/8000/1", seen, off, alu_out, err_flag);
        end
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || alu_out !== 16'h8000) begin
            errors++;
            $display("FAIL add_done_width done=%b out=%h expected 0/8000", done, alu_out);
        end
        start_op(16'h0003, 16'h0004, 16'h0000);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 0 || alu_out !== 16'h0007 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL add_plain seen=%b off=%0d out=%h err=%b expected 1/0/0007/0", seen, off, alu_out, err_flag);
        end
        start_op(16'h8000, 16'h0001, 16'h0001);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h7FFF || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf out=%h err=%b expected 7FFF/1", alu_out, err_flag);
        end
        start_op(16'h8000, 16'h0000, 16'h0009);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h8000 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL neg_min out=%h err=%b expected 8000/1", alu_out, err_flag);
        end
    endtask

    task automatic test_mul;
        int off; bit seen;
        start_op(16'hFFFD, 16'h0007, 16'h0002);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 17 || alu_out !== 16'hFFEB || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL mul_neg seen=%b off=%0d out=%h err=%b expected 1/17/FFEB/0", seen, off, alu_out, err_flag);
        end
        start_op(16'd300, 16'd300, 16'h0002);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 17 || alu_out !== 16'h5F90 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL mul_ovf seen=%b off=%0d out=%h err=%b expected 1/17/5F90/1", seen, off, alu_out, err_flag);
        end
    endtask

    task automatic test_divmod;
        int off; bit seen;
        start_op(16'hFFF9, 16'h0002, 16'h0003);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 17 || alu_out !== 16'hFFFD || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL div_neg seen=%b off=%0d out=%h err=%b expected 1/17/FFFD/0", seen, off, alu_out, err_flag);
        end
        start_op(16'hFFF9, 16'h0002, 16'h0004);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 17 || alu_out !== 16'hFFFF || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL mod_neg seen=%b off=%0d out=%h err=%b expected 1/17/FFFF/0", seen, off, alu_out, err_flag);
        end
        start_op(16'h0005, 16'h0000, 16'h0003);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 0 || alu_out !== 16'h0000 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL div_zero seen=%b off=%0d out=%h err=%b expected 1/0/0000/1", seen, off, alu_out, err_flag);
        end
        start_op(16'h8000, 16'hFFFF, 16'h0003);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h8000 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL div_min out=%h err=%b expected 8000/1", alu_out, err_flag);
        end
        start_op(16'h8000, 16'hFFFF, 16'h0004);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h0000 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL mod_min out=%h err=%b expected 0000/0", alu_out, err_flag);
        end
        start_op(16'd100, 16'hFFF9, 16'h0004);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h0002 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL mod_pos_negdiv out=%h err=%b expected 0002/0", alu_out, err_flag);
        end
    endtask

    task automatic test_logic;
        int off; bit seen;
        start_op(16'h1234, 16'h0001, 16'h0010);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 0 || alu_out !== 16'h0000 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op seen=%b off=%0d out=%h err=%b expected 1/0/0000/1", seen, off, alu_out, err_flag);
        end
        start_op(16'hFFFF, 16'h0001, 16'h000E);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h0001 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL lt_signed out=%h err=%b expected 0001/0", alu_out, err_flag);
        end
        start_op(16'hFFFF, 16'h0001, 16'h000F);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h0000 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL ltu out=%h err=%b expected 0000/0", alu_out, err_flag);
        end
        start_op(16'h8000, 16'h0004, 16'h000C);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'hF800 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL sra out=%h err=%b expected F800/0", alu_out, err_flag);
        end
        start_op(16'h8001, 16'h0004, 16'h000B);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h0800) begin
            errors++;
            $display("FAIL shr out=%h expected 0800", alu_out);
        end
        start_op(16'h00F0, 16'h0F0F, 16'h0007);
        wait_done(off, seen);
        checks++;
        if (!seen || alu_out !== 16'h0FFF || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL xor out=%h err=%b expected 0FFF/0", alu_out, err_flag);
        end
    endtask

    task automatic test_back_to_back;
        int off; bit seen; int n;
        logic [15:0] last;
        start_op(16'd100, 16'd7, 16'h0003);
        repeat (3) @(posedge clock);
        @(negedge clock);
        alu_a  = 16'h0001;
        alu_b  = 16'h0001;
        alu_op = 16'h0000;
        go     = 1'b1;
        @(posedge clock);
        #1;
        go   = 1'b0;
        n    = 0;
        last = 16'hDEAD;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                n++;
                last = alu_out;
            end
        end
        checks++;
        if (n !== 1 || last !== 16'h000E) begin
            errors++;
            $display("FAIL go_ignored dones=%0d out=%h expected 1/000E", n, last);
        end
        start_op(16'h0005, 16'h0003, 16'h0002);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 17 || alu_out !== 16'h000F) begin
            errors++;
            $display("FAIL mul_small seen=%b off=%0d out=%h expected 1/17/000F", seen, off, alu_out);
        end
        start_op(16'h0002, 16'h0003, 16'h0000);
        wait_done(off, seen);
        checks++;
        if (!seen || off !== 0 || alu_out !== 16'h0005 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL go_in_done_cycle seen=%b off=%0d out=%h err=%b expected 1/0/0005/0", seen, off, alu_out, err_flag);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start_op(16'd300, 16'd300, 16'h0002);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        checks++;
        if (alu_out !== 16'h0000 || err_flag !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs out=%h err=%b done=%b expected 0000/0/0", alu_out, err_flag, done);
        end
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            if (done) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d dones expected 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_divmod();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Multi-cycle 16-bit two's-complement ALU for the stack machine's Lisp evaluator. The sequencer pops two operands, presents them with an opcode and a one-cycle `go` strobe, then waits for `done`. It returns one 16-bit result and an error flag. Single-cycle ops finish in 1 cycle. MUL/DIV/MOD use a shared 16-iteration shift datapath.

## Interface
- No parameters; data width fixed at 16.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-high reset (the name is the codebase name; polarity is high).
- alu_a  in  16  first operand (stack next-of-top); sampled only on an accepted `go`.
- alu_b  in  16  second operand (stack top); sampled only on an accepted `go`.
- alu_op  in  16  opcode; bits [3:0] select the op; bits [15:4] must be 0.
- go  in  1  start strobe; honoured only in IDLE.
- alu_out  out  16  result; registered; held until the next accepted `go`.
- done  out  1  one-cycle completion pulse.
- err_flag  out  1  error status of the last operation; registered; valid with `done`; held until the next accepted `go`.

## Operation
- Opcodes: 0 ADD, 1 SUB (a−b), 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 NOT (~a), 9 NEG (−a), A SHL (a<<b[3:0]), B SHR (logical), C SRA (arithmetic), D EQ, E LT (signed a<b), F LTU.
- EQ/LT/LTU produce 16'h0001 for true and 16'h0000 for false.
- ADD, SUB, NEG:
  - Result wraps modulo 2^16.
  - err_flag=1 on signed overflow. NEG of 16'h8000 returns 16'h8000 with err.
- MUL:
  - Returns the low 16 bits of the signed product.
  - err_flag=1 when the full 32-bit product is outside −32768..32767.
- DIV:
  - Signed, truncates toward zero.
  - 16'h8000 / 16'hFFFF returns 16'h8000 with err=1.
- MOD:
  - Remainder takes the sign of the dividend: a = (a/b)*b + a%b.
  - 16'h8000 % 16'hFFFF returns 0 with no error.
- Divide by zero (DIV or MOD with b=0): alu_out=0, err=1.
- Illegal opcode (alu_op[15:4]≠0): alu_out=0, err=1, no computation.
- Logic and shift ops never set err.

## Timing
- States: IDLE, ITER (16-step multiply/divide), FIX (sign correction and error check), FIN.
- Reset:
  - Forces IDLE.
  - alu_out=0, done=0, err_flag=0; iteration counter=0.
  - Reset mid-operation aborts it; no `done` is produced.
- Accepting an operation: `go`=1 sampled in IDLE at edge k latches alu_a, alu_b and alu_op.
- Single-cycle ops, illegal opcode, and divide-by-zero: result and err registered at edge k; done=1 for the cycle after edge k (latency 1).
- MUL/DIV/MOD:
  - ITER runs 16 cycles on magnitudes.
  - FIX takes 1 cycle for sign correction and the overflow check.
  - done=1 for the single cycle after edge k+17.
- `go` outside IDLE (ITER/FIX/FIN) is ignored; it is not queued.
- done is high for exactly one cycle per accepted `go`. The machine is back in IDLE during the done cycle, so a new `go` in that cycle is accepted.
- alu_out and err_flag change only when done rises or on reset.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode enum (4-bit values above),
  - the state enum,
  - constants `ALU_W=16` and `ITER_CNT=16`.
- One natural sub-module: `alu_muldiv`. It is an iterative shift-add multiplier and restoring divider sharing one 32-bit accumulator and a 5-bit counter.
  - Inputs: magnitudes plus a start strobe.
  - Outputs: product/quotient/remainder and a ready signal.
- The top-level block holds:
  - the combinational single-cycle ops,
  - sign handling,
  - error detection,
  - the FSM.

## Test plan
- Reset then idle: reset_n=1 for 2 cycles, then 0 → alu_out=0, done=0, err_flag=0; no done without go.
- ADD: a=16'h7FFF, b=1, op=0, go → done 1 cycle later; alu_out=16'h8000, err=1. Then a=3, b=4 → 7, err=0.
- MUL: a=−3 (16'hFFFD), b=7, op=2 → done exactly 17 cycles after the go edge; alu_out=16'hFFEB (−21), err=0. Then a=300, b=300 → err=1.
- DIV/MOD:
  - a=−7, b=2: op=3 → 16'hFFFD (−3); op=4 → 16'hFFFF (−1).
  - a=5, b=0, op=3 → alu_out=0, err=1, latency 1.
- Illegal and compare ops:
  - op=16'h0010 → alu_out=0, err=1.
  - op=E, a=16'hFFFF, b=1 → 1.
  - op=F with the same operands → 0.
  - SRA: a=16'h8000, b=4 → 16'hF800.
- Handshake:
  - A go pulse during a DIV is ignored: exactly one done.
  - A go in the done cycle starts a new op.
  - reset_n=1 mid-MUL → no done, outputs 0.
